// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between NREQ requesters.
// Optional grant locking for back-to-back ops is enabled by defining ALU_ARBITER_LOCK_EN.
module alu_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_f,
   input  logic [NREQ-1:0]       req_lock,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  rsp_zero,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [2:0]            alu_f,
   input  logic [WIDTH-1:0]      alu_y,
   input  logic                  alu_zero,
   output logic                  busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [PW-1:0] ptr, ptr_next;
   logic [PW-1:0] owner, owner_next;
   logic [PW-1:0] start, win, cand;
   logic          found;
   logic          locked, locked_next;
   logic          lock_hold, lock_req;

   logic [WIDTH-1:0] a_arr [NREQ];
   logic [WIDTH-1:0] b_arr [NREQ];
   logic [2:0]       f_arr [NREQ];

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
      return (x == LAST) ? '0 : x + PW'(1);
   endfunction

   // Unpack the flat request buses into per-requester views
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
      assign f_arr[g] = req_f[g*3 +: 3];
   end

`ifdef ALU_ARBITER_LOCK_EN
   assign lock_req  = req_lock[owner];
   assign lock_hold = locked & req_lock[owner];
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign lock_req    = 1'b0;
   assign lock_hold   = 1'b0;
`endif

   // Winner search; a released lock resumes arbitration just past the old owner
   always_comb begin
      start = locked ? wrap_inc(owner) : ptr;
      found = 1'b0;
      win   = '0;
      cand  = '0;
      if (lock_hold) begin
         found = req_valid[owner];
         win   = owner;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(start) + k) % NREQ);
            if (!found && req_valid[cand]) begin
               found = 1'b1;
               win   = cand;
            end
         end
      end
   end

   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      owner_next  = owner;
      locked_next = locked;
      req_ready   = '0;
      case (state)
         IDLE: begin
            if (locked && !lock_hold) begin
               locked_next = 1'b0;
               ptr_next    = start;
            end
            if (found) begin
               req_ready[win] = 1'b1;
               owner_next     = win;
               state_next     = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_ready[owner]) begin
               state_next = IDLE;
               if (lock_req) begin
                  locked_next = 1'b1;
               end else begin
                  ptr_next = wrap_inc(owner);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         locked    <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_f     <= '0;
         rsp_y     <= '0;
         rsp_zero  <= 1'b0;
         rsp_valid <= '0;
         busy      <= 1'b0;
      end else begin
         state  <= state_next;
         ptr    <= ptr_next;
         owner  <= owner_next;
         locked <= locked_next;
         if (state == IDLE && found) begin
            alu_a <= a_arr[win];
            alu_b <= b_arr[win];
            alu_f <= f_arr[win];
         end
         if (state == EXEC) begin
            rsp_y    <= alu_y;
            rsp_zero <= alu_zero;
         end
         rsp_valid <= (state_next == RESP) ? (NREQ'(1) << owner_next) : '0;
         busy      <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard and corner sequences.
// Define ALU_ARBITER_LOCK_EN to exercise the grant-lock feature.
module tb_alu_arbiter;

   localparam int unsigned NREQ  = 2;
   localparam int unsigned WIDTH = 32;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req_valid, req_ready, req_lock, rsp_valid, rsp_ready;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ*3-1:0]     req_f;
   logic [WIDTH-1:0]      rsp_y, alu_a, alu_b, alu_y;
   logic [2:0]            alu_f;
   logic                  rsp_zero, alu_zero, busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_f(req_f), .req_lock(req_lock),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_y(alu_y), .alu_zero(alu_zero), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: and, or, add, a&~b, a|~b, sub, signed set-less-than
   function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] f);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_y    = alu_ref(alu_a, alu_b, alu_f);
      alu_zero = (alu_y == '0);
   end

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] f);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_f[i*3 +: 3]         = f;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      rsp_ready = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Scoreboard: expectation pushed at acceptance, popped at response handshake
   typedef struct {
      int              idx;
      logic [WIDTH-1:0] y;
      logic            zero;
   } exp_t;
   exp_t sb[$];

   always begin : monitor
      exp_t e;
      @(negedge clk);
      #2;
      if (reset) begin
         sb.delete();
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
               e.idx  = i;
               e.y    = alu_ref(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_f[i*3 +: 3]);
               e.zero = (e.y == '0);
               sb.push_back(e);
            end
         end
         if (|(rsp_valid & rsp_ready)) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_rsp", 64'(rsp_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               check("sb_owner", 64'(rsp_valid), 64'(oh(e.idx)));
               check("sb_y", 64'(rsp_y), 64'(e.y));
               check("sb_zero", 64'(rsp_zero), 64'(e.zero));
            end
         end
      end
   end

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       f;
      logic [WIDTH-1:0] y;
      logic             z;
   } vec_t;
   vec_t vecs[8];

   logic [NREQ-1:0] exp_rdy;

   initial begin
      vecs[0] = '{0, 32'd5,          32'd3,      3'b010, 32'd8,      1'b0};
      vecs[1] = '{1, 32'd7,          32'd7,      3'b110, 32'd0,      1'b1};
      vecs[2] = '{0, 32'hffff_ffff,  32'd1,      3'b010, 32'd0,      1'b1};
      vecs[3] = '{1, 32'h0000_f0f0,  32'h0000_ff00, 3'b000, 32'h0000_f000, 1'b0};
      vecs[4] = '{0, 32'h0000_f0f0,  32'h0000_0f00, 3'b001, 32'h0000_fff0, 1'b0};
      vecs[5] = '{1, 32'hffff_fffe,  32'd2,      3'b111, 32'd1,      1'b0};
      vecs[6] = '{0, 32'd9,          32'd2,      3'b111, 32'd0,      1'b1};
      vecs[7] = '{1, 32'h0000_00ff,  32'h0000_000f, 3'b100, 32'h0000_00f0, 1'b0};

      reset     = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      req_f     = '0;

      @(negedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_alu_a", 64'(alu_a), 64'(0));
      check("rst_alu_f", 64'(alu_f), 64'(0));
      check("rst_rsp_y", 64'(rsp_y), 64'(0));
      @(negedge clk);
      reset = 1'b0;

      // Single operations, 3-cycle timeline each
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         set_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].f);
         req_valid = oh(vecs[v].idx);
         rsp_ready = '1;
         #1;
         check("vec_grant", 64'(req_ready), 64'(oh(vecs[v].idx)));
         check("vec_idle_busy", 64'(busy), 64'(0));
         @(negedge clk);
         req_valid = '0;
         #1;
         check("vec_exec_busy", 64'(busy), 64'(1));
         check("vec_exec_rsp_valid", 64'(rsp_valid), 64'(0));
         check("vec_alu_a", 64'(alu_a), 64'(vecs[v].a));
         check("vec_alu_f", 64'(alu_f), 64'(vecs[v].f));
         @(negedge clk);
         #1;
         check("vec_rsp_valid", 64'(rsp_valid), 64'(oh(vecs[v].idx)));
         check("vec_rsp_y", 64'(rsp_y), 64'(vecs[v].y));
         check("vec_rsp_zero", 64'(rsp_zero), 64'(vecs[v].z));
      end

      // Contention: both requesters hold valid, grants alternate every 3 cycles
      do_reset();
      set_op(0, 32'd10, 32'd4, 3'b110);
      set_op(1, 32'd8, 32'd8, 3'b110);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         exp_rdy = (c % 3 == 0) ? oh((c / 3) % 2) : '0;
         check("rr_grant", 64'(req_ready), 64'(exp_rdy));
      end
      req_valid = '0;

      // Backpressure on the owner; non-owner ready and pending request ignored
      @(negedge clk);
      set_op(0, 32'd20, 32'd22, 3'b010);
      set_op(1, 32'd3, 32'd4, 3'b000);
      req_valid = 2'b01;
      rsp_ready = 2'b10;
      #1;
      check("bp_grant", 64'(req_ready), 64'(2'b01));
      @(negedge clk);
      req_valid = 2'b10;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         check("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
         check("bp_rsp_y", 64'(rsp_y), 64'(42));
         check("bp_req_ready", 64'(req_ready), 64'(0));
         check("bp_busy", 64'(busy), 64'(1));
      end
      @(negedge clk);
      rsp_ready = 2'b11;
      #1;
      check("bp_release_valid", 64'(rsp_valid), 64'(2'b01));
      @(negedge clk);
      #1;
      check("bp_idle_busy", 64'(busy), 64'(0));
      check("bp_next_grant", 64'(req_ready), 64'(2'b10));
      @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);

      // Reset while EXEC: op discarded, next op arbitrates from requester 0
      @(negedge clk);
      set_op(0, 32'd1, 32'd2, 3'b010);
      set_op(1, 32'd6, 32'd3, 3'b110);
      req_valid = 2'b01;
      rsp_ready = 2'b11;
      #1;
      check("rst_mid_grant", 64'(req_ready), 64'(2'b01));
      @(negedge clk);
      req_valid = '0;
      reset     = 1'b1;
      #1;
      check("rst_mid_exec_busy", 64'(busy), 64'(1));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid_busy", 64'(busy), 64'(0));
      check("rst_mid_alu_a", 64'(alu_a), 64'(0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));
      end
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("rst_mid_ptr0", 64'(req_ready), 64'(2'b01));
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      check("rst_mid_rsp_y", 64'(rsp_y), 64'(3));

      // Lock on requester 0: locked build repeats owner, default build alternates
      do_reset();
      set_op(0, 32'd15, 32'd5, 3'b010);
      set_op(1, 32'd4, 32'd9, 3'b111);
      req_valid = 2'b11;
      req_lock  = 2'b01;
      rsp_ready = 2'b11;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) @(negedge clk);
         if (c == 7) req_lock = 2'b00;
`ifdef ALU_ARBITER_LOCK_EN
         exp_rdy = (c % 3 != 0) ? '0 : (c < 9) ? 2'b01 : 2'b10;
`else
         exp_rdy = (c % 3 == 0) ? oh((c / 3) % 2) : '0;
`endif
         #1;
         check("lock_grant", 64'(req_ready), 64'(exp_rdy));
      end
      req_valid = '0;
      req_lock  = '0;
      repeat (3) @(negedge clk);
      #3;
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
